// File: rtl/pc_unit.sv
// pc_unit: program-counter unit for the multicycle core.
// Owns the PC register, the exception PC (EPC) and a circular return-address
// stack (RAS), and computes the next-PC candidate for the controller.
//
// Ports:
//   clk, rstn              clock, asynchronous active-low reset
//   pc_we                  PC update strobe; also qualifies ras_push/ras_pop
//   npc_op[2:0]            next-PC selector (PLUS4 .. HOLD)
//   imm[25:0]              instruction immediate field
//   rs_val[XLEN-1:0]       register operand for register-indirect jumps
//   ras_push, ras_pop      return-stack controls
//   pc, epc                registered PC and exception PC
//   npc                    combinational next-PC candidate
//   ras_top                top-of-stack value, 0 when empty
//   ras_empty, ras_full    stack occupancy flags
//   misalign               JR target has nonzero low bits
module pc_unit #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pc_we,
  input  logic [2:0]      npc_op,
  input  logic [25:0]     imm,
  input  logic [XLEN-1:0] rs_val,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            misalign
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  localparam logic [XLEN-1:0] RstPc  = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] ExcVec = XLEN'(EXC_VEC);
  localparam logic [CntW-1:0] CntMax = CntW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OpPlus4  = 3'b000,
    OpBranch = 3'b001,
    OpJump   = 3'b010,
    OpJr     = 3'b011,
    OpRas    = 3'b100,
    OpExc    = 3'b101,
    OpEret   = 3'b110,
    OpHold   = 3'b111
  } npc_op_e;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            ras_wr;
  logic [PtrW-1:0] ras_wr_idx;

  npc_op_e         op;
  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] simm;
  logic [XLEN-1:0] jr_tgt;
  logic            is_exc;

  assign op     = npc_op_e'(npc_op);
  assign is_exc = (op == OpExc);
  assign pc4    = pc_q + XLEN'(4);
  assign simm   = {{(XLEN-18){imm[15]}}, imm[15:0], 2'b00};
  assign jr_tgt = {rs_val[XLEN-1:2], 2'b00};

  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CntMax);
  // ptr_q always addresses the most recently pushed entry.
  assign ras_top   = ras_empty ? '0 : ras_q[ptr_q];

  assign pc       = pc_q;
  assign epc      = epc_q;
  assign misalign = (op == OpJr) && (rs_val[1:0] != 2'b00);

  always_comb begin
    npc = pc_q;
    unique case (op)
      OpPlus4:  npc = pc4;
      OpBranch: npc = pc4 + simm;
      OpJump:   npc = {pc4[XLEN-1:28], imm, 2'b00};
      OpJr:     npc = jr_tgt;
      OpRas:    npc = ras_empty ? jr_tgt : ras_top;
      OpExc:    npc = ExcVec;
      OpEret:   npc = epc_q;
      OpHold:   npc = pc_q;
      default:  npc = pc_q;
    endcase
  end

  // RAS next state; only committed when pc_we is high.
  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    ras_wr     = 1'b0;
    ras_wr_idx = ptr_q;
    if (!is_exc) begin
      if (ras_push && (!ras_pop || ras_empty)) begin
        // Full push wraps onto the oldest entry.
        ras_wr     = 1'b1;
        ras_wr_idx = ptr_q + PtrW'(1);
        ptr_d      = ptr_q + PtrW'(1);
        cnt_d      = ras_full ? cnt_q : cnt_q + CntW'(1);
      end else if (ras_push && ras_pop) begin
        ras_wr     = 1'b1;
        ras_wr_idx = ptr_q;
      end else if (ras_pop && !ras_empty) begin
        ptr_d = ptr_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q  <= RstPc;
      epc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (pc_we) begin
      pc_q  <= npc;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (is_exc) begin
        epc_q <= pc_q;
      end
      if (ras_wr) begin
        ras_q[ras_wr_idx] <= pc4;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pc_we;
  logic [2:0]  npc_op;
  logic [25:0] imm;
  logic [31:0] rs_val;
  logic        ras_push, ras_pop;
  logic [31:0] pc, npc, epc, ras_top;
  logic        ras_empty, ras_full, misalign;

  int checks = 0;
  int errors = 0;

  // Behavioural model: the RAS is a plain list, newest entry at the back.
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_stack [$];

  always #5 clk = ~clk;

  pc_unit #(
    .XLEN(32), .RESET_PC(32'h0000_3000), .EXC_VEC(32'h0000_4180), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .pc_we(pc_we), .npc_op(npc_op), .imm(imm), .rs_val(rs_val),
    .ras_push(ras_push), .ras_pop(ras_pop), .pc(pc), .npc(npc), .epc(epc),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_npc();
    logic [31:0] p4;
    int off;
    p4  = m_pc + 32'd4;
    off = $signed(imm[15:0]);
    case (npc_op)
      3'd0: return p4;
      3'd1: return p4 + 32'(off * 4);
      3'd2: return (p4 & 32'hF000_0000) | (32'(imm) << 2);
      3'd3: return rs_val & ~32'd3;
      3'd4: return (m_stack.size() > 0) ? m_stack[$] : (rs_val & ~32'd3);
      3'd5: return 32'h0000_4180;
      3'd6: return m_epc;
      default: return m_pc;
    endcase
  endfunction

  function automatic logic [31:0] m_top();
    return (m_stack.size() > 0) ? m_stack[$] : 32'd0;
  endfunction

  task automatic model_reset();
    m_pc  = 32'h0000_3000;
    m_epc = 32'd0;
    m_stack.delete();
  endtask

  task automatic model_step();
    logic [31:0] nxt, p4;
    if (!rstn || !pc_we) return;
    nxt = m_npc();
    p4  = m_pc + 32'd4;
    if (npc_op == 3'd5) begin
      m_epc = m_pc;
    end else if (ras_push && ras_pop && m_stack.size() > 0) begin
      m_stack[m_stack.size()-1] = p4;
    end else if (ras_push) begin
      m_stack.push_back(p4);
      if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
    end else if (ras_pop && m_stack.size() > 0) begin
      void'(m_stack.pop_back());
    end
    m_pc = nxt;
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    check("pc", pc, m_pc);
    check("epc", epc, m_epc);
    check("ras_top", ras_top, m_top());
    check("ras_empty", 32'(ras_empty), 32'(m_stack.size() == 0));
    check("ras_full", 32'(ras_full), 32'(m_stack.size() == DEPTH));
    check("npc", npc, m_npc());
    check("misalign", 32'(misalign), 32'(npc_op == 3'd3 && rs_val[1:0] != 2'b00));
  end

  task automatic drive(input logic we, input logic [2:0] op, input logic [25:0] im,
                       input logic [31:0] rs, input logic pu, input logic po);
    pc_we = we; npc_op = op; imm = im; rs_val = rs; ras_push = pu; ras_pop = po;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_epc", epc, 32'd0);
    check("rst_empty", 32'(ras_empty), 32'd1);
    step();
    rstn = 1'b1;
  endtask

  logic [31:0] pops [4];

  initial begin
    rstn = 1'b0;
    drive(1'b0, 3'd7, 26'd0, 32'd0, 1'b0, 1'b0);
    model_reset();
    #12 rstn = 1'b1;
    step();
    check("rst_pc0", pc, 32'h0000_3000);

    // Sequential and branch.
    repeat (3) begin drive(1'b1, 3'd0, 26'd0, 32'd0, 1'b0, 1'b0); step(); end
    check("plus4x3", pc, 32'h0000_300C);
    step();
    drive(1'b0, 3'd1, 26'h000FFFC, 32'd0, 1'b0, 1'b0); #1;
    check("branch_neg", npc, 32'h0000_3004);
    drive(1'b0, 3'd1, 26'h0000003, 32'd0, 1'b0, 1'b0); #1;
    check("branch_pos", npc, 32'h0000_3020);

    // Jump and JR after a mid-run reset.
    do_reset();
    drive(1'b0, 3'd2, 26'h0000C10, 32'd0, 1'b0, 1'b0); #1;
    check("jump", npc, 32'h0000_3040);
    drive(1'b0, 3'd3, 26'd0, 32'h0000_3103, 1'b0, 1'b0); #1;
    check("jr", npc, 32'h0000_3100);
    check("jr_misalign", 32'(misalign), 32'd1);

    // Exception entry and return.
    drive(1'b1, 3'd3, 26'd0, 32'h0000_3050, 1'b0, 1'b0); step();
    check("jr_pc", pc, 32'h0000_3050);
    drive(1'b1, 3'd5, 26'd0, 32'd0, 1'b1, 1'b0); step();
    check("exc_pc", pc, 32'h0000_4180);
    check("exc_epc", epc, 32'h0000_3050);
    check("exc_ras", 32'(ras_empty), 32'd1);
    drive(1'b1, 3'd6, 26'd0, 32'd0, 1'b0, 1'b0); step();
    check("eret_pc", pc, 32'h0000_3050);

    // RAS overflow then drain.
    do_reset();
    repeat (5) begin drive(1'b1, 3'd0, 26'd0, 32'd0, 1'b1, 1'b0); step(); end
    check("ras_full5", 32'(ras_full), 32'd1);
    check("ras_top5", ras_top, 32'h0000_3014);
    pops[0] = 32'h3014; pops[1] = 32'h3010; pops[2] = 32'h300C; pops[3] = 32'h3008;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd4, 26'd0, 32'h0000_3200, 1'b0, 1'b1); #1;
      check("ras_pop", npc, pops[i]);
      step();
    end
    drive(1'b1, 3'd4, 26'd0, 32'h0000_3200, 1'b0, 1'b1); #1;
    check("ras_fallback", npc, 32'h0000_3200);
    step();
    check("ras_empty5", 32'(ras_empty), 32'd1);
    check("ras_fb_pc", pc, 32'h0000_3200);

    // Simultaneous push+pop keeps depth, replaces top.
    repeat (2) begin drive(1'b1, 3'd0, 26'd0, 32'd0, 1'b1, 1'b0); step(); end
    drive(1'b1, 3'd0, 26'd0, 32'd0, 1'b1, 1'b1); step();
    check("pushpop_top", ras_top, 32'h0000_320C);
    drive(1'b1, 3'd0, 26'd0, 32'd0, 1'b0, 1'b1); step();
    check("pushpop_cnt", ras_top, 32'h0000_3204);
    drive(1'b0, 3'd0, 26'd0, 32'd0, 1'b1, 1'b0); step();
    check("nowe_top", ras_top, 32'h0000_3204);
    check("nowe_pc", pc, 32'h0000_3210);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 26'($urandom),
            $urandom, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 199) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
